// File: rtl/pong_pkg.sv
// Shared constants and types for the screen sequencer: screen codes,
// menu button geometry, FSM states and the button hit-test helper.
package pong_pkg;

    localparam logic [1:0] SCR_MENU    = 2'd0;
    localparam logic [1:0] SCR_GAME    = 2'd1;
    localparam logic [1:0] SCR_CREDITS = 2'd2;

    localparam logic [11:0] BTN_X_MIN   = 12'd362;
    localparam logic [11:0] BTN_X_MAX   = 12'd674;
    localparam logic [11:0] BTN_H       = 12'd100;
    localparam logic [11:0] START_Y_MIN = 12'd46;
    localparam logic [11:0] DIFF_Y_MIN  = 12'd238;
    localparam logic [11:0] COLOR_Y_MIN = 12'd430;
    localparam logic [11:0] CRED_Y_MIN  = 12'd622;

    localparam int NUM_COLORS  = 7;
    localparam int FADE_FRAMES = 2;

    typedef enum logic [1:0] {
        ST_MENU,
        ST_TRANS,
        ST_GAME,
        ST_CREDITS
    } state_t;

    typedef struct packed {
        logic start;
        logic diff;
        logic color;
        logic cred;
    } hit_t;

    // All rectangle edges are inclusive.
    function automatic logic in_rect(
        input logic [11:0] x,
        input logic [11:0] y,
        input logic [11:0] x_min,
        input logic [11:0] x_max,
        input logic [11:0] y_min,
        input logic [11:0] h
    );
        return (x >= x_min) && (x <= x_max) && (y >= y_min) && (y <= y_min + h);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// One-cycle rising-edge detector: registered copy of the level, edge output
// is level & ~delayed level.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_level_d <= 1'b0;
        else     r_level_d <= i_level;
    end

    assign o_rise = i_level & ~r_level_d;

endmodule

// File: rtl/screen_sequencer.sv
// Top-level screen FSM: turns mouse/button levels into events, hit-tests menu
// buttons, owns difficulty/colour settings and runs the blanked transitions.
module screen_sequencer
    import pong_pkg::*;
#(
    parameter logic [11:0] P_BTN_X_MIN   = BTN_X_MIN,
    parameter logic [11:0] P_BTN_X_MAX   = BTN_X_MAX,
    parameter logic [11:0] P_BTN_H       = BTN_H,
    parameter logic [11:0] P_START_Y_MIN = START_Y_MIN,
    parameter logic [11:0] P_DIFF_Y_MIN  = DIFF_Y_MIN,
    parameter logic [11:0] P_COLOR_Y_MIN = COLOR_Y_MIN,
    parameter logic [11:0] P_CRED_Y_MIN  = CRED_Y_MIN,
    parameter int          P_NUM_COLORS  = NUM_COLORS,
    parameter int          P_FADE_FRAMES = FADE_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        button,
    output logic [1:0]  screen,
    output logic        blank_out,
    output logic        difficulty,
    output logic [2:0]  color_state,
    output logic        switch_pulse
);

    localparam int              CNT_W      = (P_FADE_FRAMES > 1) ? $clog2(P_FADE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P_FADE_FRAMES - 1);
    localparam logic [2:0]      COLOR_LAST = 3'(P_NUM_COLORS - 1);

    // Edge detector lanes: 0 = mouse click, 1 = button press, 2 = vsync.
    logic [2:0] w_levels;
    logic [2:0] w_rises;
    logic       w_click, w_press, w_vs_edge;

    assign w_levels = {vsync_in, button, mouse_left};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            edge_detect u_edge (
                .clk     (clk),
                .rst     (rst),
                .i_level (w_levels[gi]),
                .o_rise  (w_rises[gi])
            );
        end
    endgenerate

    assign w_click   = w_rises[0];
    assign w_press   = w_rises[1];
    assign w_vs_edge = w_rises[2];

    hit_t w_hit_now;
    hit_t r_hit;

    always_comb begin
        w_hit_now       = '0;
        w_hit_now.start = in_rect(xpos, ypos, P_BTN_X_MIN, P_BTN_X_MAX, P_START_Y_MIN, P_BTN_H);
        w_hit_now.diff  = in_rect(xpos, ypos, P_BTN_X_MIN, P_BTN_X_MAX, P_DIFF_Y_MIN,  P_BTN_H);
        w_hit_now.color = in_rect(xpos, ypos, P_BTN_X_MIN, P_BTN_X_MAX, P_COLOR_Y_MIN, P_BTN_H);
        w_hit_now.cred  = in_rect(xpos, ypos, P_BTN_X_MIN, P_BTN_X_MAX, P_CRED_Y_MIN,  P_BTN_H);
    end

    state_t           r_state, w_state_next;
    state_t           r_target, w_target_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [1:0]       r_screen, w_screen_next;
    logic             r_blank, w_blank_next;
    logic             r_diff, w_diff_next;
    logic [2:0]       r_color, w_color_next;
    logic             r_pulse, w_pulse_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_MENU;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit    <= '0;
            r_target <= ST_MENU;
            r_cnt    <= '0;
            r_screen <= SCR_MENU;
            r_blank  <= 1'b0;
            r_diff   <= 1'b0;
            r_color  <= 3'd0;
            r_pulse  <= 1'b0;
        end else begin
            r_hit    <= w_click ? w_hit_now : hit_t'('0);
            r_target <= w_target_next;
            r_cnt    <= w_cnt_next;
            r_screen <= w_screen_next;
            r_blank  <= w_blank_next;
            r_diff   <= w_diff_next;
            r_color  <= w_color_next;
            r_pulse  <= w_pulse_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_cnt_next    = r_cnt;
        w_screen_next = r_screen;
        w_blank_next  = r_blank;
        w_diff_next   = r_diff;
        w_color_next  = r_color;
        w_pulse_next  = 1'b0;
        unique case (r_state)
            ST_MENU: begin
                if (r_hit.start || r_hit.cred) begin
                    w_state_next  = ST_TRANS;
                    w_target_next = r_hit.start ? ST_GAME : ST_CREDITS;
                    w_cnt_next    = '0;
                    w_blank_next  = 1'b1;
                end else if (r_hit.diff) begin
                    w_diff_next = ~r_diff;
                end else if (r_hit.color) begin
                    w_color_next = (r_color == COLOR_LAST) ? 3'd0 : r_color + 3'd1;
                end
            end
            ST_GAME, ST_CREDITS: begin
                if (w_press) begin
                    w_state_next  = ST_TRANS;
                    w_target_next = ST_MENU;
                    w_cnt_next    = '0;
                    w_blank_next  = 1'b1;
                end
            end
            ST_TRANS: begin
                // The entry cycle runs in the source state, so its vsync edge is never counted.
                if (w_vs_edge) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next  = r_target;
                        w_blank_next  = 1'b0;
                        w_pulse_next  = 1'b1;
                        w_screen_next = (r_target == ST_GAME)    ? SCR_GAME :
                                        (r_target == ST_CREDITS) ? SCR_CREDITS : SCR_MENU;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_MENU;
        endcase
    end

    assign screen       = r_screen;
    assign blank_out    = r_blank;
    assign difficulty   = r_diff;
    assign color_state  = r_color;
    assign switch_pulse = r_pulse;

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Owns the top-level screen state (menu/game/credits) and the user settings: difficulty and colour scheme.
- Converts raw mouse_left and button levels into single click events, then hit-tests clicks against the four menu buttons.
- Sequences screen changes through a frame-counted blanking transition.
- Sits between the mouse/button inputs and the video mux that selects menu or game rendering, and drives that mux's select and blank controls.

Parameters:
- BTN_X_MIN, 362, left edge of all menu buttons (inclusive)
- BTN_X_MAX, 674, right edge of all menu buttons (inclusive)
- BTN_H, 100, button height; each button spans Y_MIN..Y_MIN+BTN_H inclusive
- START_Y_MIN, 46, top of START button
- DIFF_Y_MIN, 238, top of DIFFICULTY button
- COLOR_Y_MIN, 430, top of COLOUR button
- CRED_Y_MIN, 622, top of CREDITS button
- NUM_COLORS, 7, colour schemes 0..NUM_COLORS-1
- FADE_FRAMES, 2, vsync rising edges spent blanked per transition; must be >= 1

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-high reset
- vsync_in  in  1  vertical sync from timing chain
- mouse_left  in  1  left mouse button level, clk domain
- xpos  in  12  mouse X
- ypos  in  12  mouse Y
- button  in  1  board push-button level, clk domain
- screen  out  2  0 = MENU, 1 = GAME, 2 = CREDITS
- blank_out  out  1  force black RGB while high
- difficulty  out  1  current difficulty
- color_state  out  3  current colour scheme index
- switch_pulse  out  1  one-cycle pulse when screen changes

Behaviour:
- Reset (async, rst = 1): FSM = MENU, screen = 0, blank_out = 0, difficulty = 0, color_state = 0, switch_pulse = 0. All edge-detect history is cleared to 0 and the fade counter is cleared.
- Edge detection:
  - click = mouse_left & ~mouse_left_d.
  - press = button & ~button_d.
  - vs_edge = vsync_in & ~vsync_d.
  - A held level never repeats an event.
- Hit stage (cycle N+1):
  - In the cycle where click = 1 (cycle N), xpos/ypos are compared and a one-hot hit_q (START, DIFF, COLOR, CRED) is registered.
  - A miss registers all-zero.
  - Coordinates exactly on any edge count as a hit.
- Action stage (cycle N+2): hit_q is acted on, so settings and state change 2 clocks after mouse_left is first sampled high.
- FSM states: MENU, TRANS, GAME, CREDITS.
- MENU:
  - START hit -> TRANS, target = GAME.
  - CRED hit -> TRANS, target = CREDITS.
  - DIFF hit -> difficulty toggles.
  - COLOR hit -> color_state increments; wraps from NUM_COLORS-1 to 0.
  - press is ignored.
- GAME / CREDITS: press -> TRANS, target = MENU. Clicks do not change settings or state.
- TRANS:
  - blank_out = 1 from the entry cycle.
  - screen holds the old value.
  - The fade counter starts at 0 on entry and increments on each vs_edge.
  - On the vs_edge where counter == FADE_FRAMES-1: screen <= target, FSM <= target, blank_out <= 0, switch_pulse <= 1 for one cycle.
  - All clicks and presses are ignored for the whole of TRANS.
  - A vs_edge in the entry cycle itself is not counted.
- Simultaneous events:
  - press and a MENU hit in the same cycle: the hit wins (press is ignored in MENU).
  - A click edge occurring while hit_q is still pending is captured normally, since hits are one per cycle.
- Outputs are registered; no combinational path from inputs to outputs.
- rst asserted mid-TRANS: returns immediately to MENU with blank_out = 0; settings are cleared.

Decomposition:
- pong_pkg holds:
  - screen encodings SCR_MENU/SCR_GAME/SCR_CREDITS (2-bit);
  - button rectangle constants;
  - NUM_COLORS.
- top_ctl-level colour decoding stays outside this block.
- One sub-module: edge_detect (registered delay plus rising-edge output, async reset), instantiated three times for mouse_left, button and vsync_in.

Test Plan:
- Reset, then mouse_left held high for 50 cycles at (500, 280) -> difficulty 0->1 exactly once, at 2 clocks after the first high sample; no further toggles.
- Seven separate clicks at (362, 430) -> color_state steps 1,2,3,4,5,6,0.
- Click at (674, 146), FADE_FRAMES = 2 -> blank_out = 1 at N+2; screen stays 0 through the first vs_edge; on the second vs_edge screen = 1, blank_out = 0, switch_pulse high for 1 cycle.
- During TRANS, click DIFF and press button -> difficulty unchanged, final screen = GAME.
- In GAME, press button -> TRANS then MENU after 2 vs_edges. In MENU, press alone -> no change. Click at (361, 100) -> miss, no action.
- Assert rst mid-TRANS (after 1 vs_edge) -> asynchronously screen = 0, blank_out = 0, difficulty = 0, color_state = 0.
